// File: rtl/iterative_normalizer_if.sv
// Handshake bundle for iterative_normalizer: operand side (in_*) and result side (out_* plus flags).
// The master drives operands and out_ready; the slave is the normalizer itself.
interface iterative_normalizer_if #(
    parameter int exponent_size = 8,
    parameter int mantissa_size = 24
);
    logic                     in_valid;
    logic                     in_ready;
    logic [mantissa_size:0]   in_mantissa;
    logic [exponent_size-1:0] in_exponent;
    logic                     out_valid;
    logic                     out_ready;
    logic [mantissa_size-1:0] out_mantissa;
    logic [exponent_size-1:0] out_exponent;
    logic                     zero;
    logic                     underflow;
    logic                     overflow;
    logic                     sticky;

    modport master (
        output in_valid, in_mantissa, in_exponent, out_ready,
        input  in_ready, out_valid, out_mantissa, out_exponent,
               zero, underflow, overflow, sticky
    );

    modport slave (
        input  in_valid, in_mantissa, in_exponent, out_ready,
        output in_ready, out_valid, out_mantissa, out_exponent,
               zero, underflow, overflow, sticky
    );
endinterface

// File: rtl/iterative_normalizer.sv
// Post add/sub normalizer: shifts leading zeros out one bit per cycle while decrementing the exponent.
// Optional macro NORMALIZER_STICKY_EN builds a sticky flag for the bit lost in the carry right-shift.
module iterative_normalizer #(
    parameter int exponent_size = 8,
    parameter int mantissa_size = 24
) (
    input  logic                    clk,
    input  logic                    rst_n,
    iterative_normalizer_if.slave   bus
);
    localparam logic [exponent_size-1:0] exp_one = exponent_size'(1);
    localparam logic [exponent_size-1:0] exp_max = '1;

    typedef enum logic [1:0] {st_idle, st_shift, st_done} state_t;

    state_t                   state_reg, state_next;
    logic [mantissa_size-1:0] mant_reg;
    logic [exponent_size-1:0] exp_reg;
    logic                     zero_reg, underflow_reg, overflow_reg;

    logic                     accept, release_out;
    logic                     in_special, in_zero, in_carry, in_denormal, in_normal;
    logic [exponent_size-1:0] exp_inc;

    // Classification priority: Inf/NaN, zero, carry-out, denormal, then normal.
    assign in_special  = (bus.in_exponent == exp_max);
    assign in_zero     = !in_special && (bus.in_mantissa == '0);
    assign in_carry    = !in_special && !in_zero && bus.in_mantissa[mantissa_size];
    assign in_denormal = !in_special && !in_zero && !in_carry && (bus.in_exponent == '0);
    assign in_normal   = !in_special && !in_zero && !in_carry && !in_denormal;
    assign exp_inc     = bus.in_exponent + exp_one;

    assign accept      = (state_reg == st_idle) && bus.in_valid;
    assign release_out = (state_reg == st_done) && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= st_idle;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            st_idle:  if (bus.in_valid) state_next = in_normal ? st_shift : st_done;
            st_shift: if (mant_reg[mantissa_size-1] || (exp_reg == exp_one)) state_next = st_done;
            st_done:  if (bus.out_ready) state_next = st_idle;
            default:  state_next = st_idle;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_reg == st_idle);
        bus.out_valid = (state_reg == st_done);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mant_reg      <= '0;
            exp_reg       <= '0;
            zero_reg      <= 1'b0;
            underflow_reg <= 1'b0;
            overflow_reg  <= 1'b0;
        end else if (accept) begin
            zero_reg      <= 1'b0;
            underflow_reg <= 1'b0;
            overflow_reg  <= 1'b0;
            if (in_zero) begin
                mant_reg <= '0;
                exp_reg  <= '0;
                zero_reg <= 1'b1;
            end else if (in_carry) begin
                exp_reg <= exp_inc;
                if (exp_inc == exp_max) begin
                    mant_reg     <= '0;
                    overflow_reg <= 1'b1;
                end else begin
                    mant_reg <= bus.in_mantissa[mantissa_size:1];
                end
            end else begin
                // Special, denormal and normal operands all start from the unshifted mantissa.
                mant_reg      <= bus.in_mantissa[mantissa_size-1:0];
                exp_reg       <= bus.in_exponent;
                underflow_reg <= in_denormal;
            end
        end else if (state_reg == st_shift && !mant_reg[mantissa_size-1]) begin
            if (exp_reg == exp_one) begin
                exp_reg       <= '0;
                underflow_reg <= 1'b1;
            end else begin
                mant_reg <= mant_reg << 1;
                exp_reg  <= exp_reg - exp_one;
            end
        end else if (release_out) begin
            zero_reg      <= 1'b0;
            underflow_reg <= 1'b0;
            overflow_reg  <= 1'b0;
        end
    end

    assign bus.out_mantissa = mant_reg;
    assign bus.out_exponent = exp_reg;
    assign bus.zero         = zero_reg;
    assign bus.underflow    = underflow_reg;
    assign bus.overflow     = overflow_reg;

`ifdef NORMALIZER_STICKY_EN
    logic sticky_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_reg <= 1'b0;
        end else if (accept) begin
            sticky_reg <= in_carry && bus.in_mantissa[0];
        end else if (release_out) begin
            sticky_reg <= 1'b0;
        end
    end

    assign bus.sticky = sticky_reg;
`else
    assign bus.sticky = 1'b0;
`endif
endmodule

// File: tb/tb_iterative_normalizer.sv
// Self-checking bench for iterative_normalizer: directed table, random ops against a closed-form model,
// plus backpressure and mid-operation reset sequences.
module tb_iterative_normalizer;
    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

`ifdef NORMALIZER_STICKY_EN
    localparam logic sticky_on = 1'b1;
`else
    localparam logic sticky_on = 1'b0;
`endif

    typedef struct {
        logic [23:0] mant;
        logic [7:0]  expo;
        logic        z;
        logic        uf;
        logic        of;
        logic        st;
        int          lat;
    } res_t;

    typedef struct {
        logic [24:0] m;
        logic [7:0]  e;
        res_t        want;
    } vec_t;

    iterative_normalizer_if #(.exponent_size(8), .mantissa_size(24)) bus ();

    iterative_normalizer #(.exponent_size(8), .mantissa_size(24)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // Closed-form expectation: leading-zero count limited by how far the exponent can drop.
    function automatic res_t model(input logic [24:0] m, input logic [7:0] e);
        res_t        r;
        logic [23:0] lo;
        int          k;
        int          ne;
        r  = '{24'h0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        lo = m[23:0];
        if (e == 8'hFF) begin
            r.mant = lo;
            r.expo = e;
        end else if (m == 25'h0) begin
            r.z = 1'b1;
        end else if (m[24]) begin
            ne     = int'(e) + 1;
            r.expo = 8'(ne);
            r.st   = sticky_on & m[0];
            if (ne == 255) begin
                r.of = 1'b1;
            end else begin
                r.mant = m[24:1];
            end
        end else if (e == 8'h0) begin
            r.mant = lo;
            r.uf   = 1'b1;
        end else begin
            k = 0;
            while (k < 24 && lo[23-k] == 1'b0) k++;
            if (k <= int'(e) - 1) begin
                r.mant = lo << k;
                r.expo = 8'(int'(e) - k);
                r.lat  = 2 + k;
            end else begin
                r.mant = lo << (int'(e) - 1);
                r.expo = 8'h0;
                r.uf   = 1'b1;
                r.lat  = 1 + int'(e);
            end
        end
        return r;
    endfunction

    task automatic run_op(input string tag, input logic [24:0] m, input logic [7:0] e, input res_t want);
        int lat;
        int guard;
        guard = 0;
        @(negedge clk);
        while (!bus.in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_mantissa = m;
        bus.in_exponent = e;
        bus.in_valid    = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid    = 1'b0;
        bus.in_mantissa = 25'($urandom);
        bus.in_exponent = 8'($urandom);
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        $display("op %s m=%07h e=%0d -> mant=%06h exp=%0d z=%0b uf=%0b of=%0b st=%0b lat=%0d",
                 tag, m, e, bus.out_mantissa, bus.out_exponent, bus.zero, bus.underflow,
                 bus.overflow, bus.sticky, lat);
        chk({tag, ".lat"},  32'(lat), 32'(want.lat));
        chk({tag, ".mant"}, 32'(bus.out_mantissa), 32'(want.mant));
        chk({tag, ".exp"},  32'(bus.out_exponent), 32'(want.expo));
        chk({tag, ".flags"}, {28'h0, bus.zero, bus.underflow, bus.overflow, bus.sticky},
            {28'h0, want.z, want.uf, want.of, want.st});
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({tag, ".release"}, {30'h0, bus.out_valid, bus.in_ready}, 32'b01);
    endtask

    vec_t tbl[12];

    initial begin
        res_t w;
        logic [24:0] rm;
        logic [7:0]  re;
        logic [23:0] held_mant;

        tbl[0]  = '{25'h0800000, 8'd100, '{24'h800000, 8'd100, 1'b0, 1'b0, 1'b0, 1'b0, 2}};
        tbl[1]  = '{25'h0000001, 8'd100, '{24'h800000, 8'd77,  1'b0, 1'b0, 1'b0, 1'b0, 25}};
        tbl[2]  = '{25'h0000100, 8'd5,   '{24'h001000, 8'd0,   1'b0, 1'b1, 1'b0, 1'b0, 6}};
        tbl[3]  = '{25'h1800001, 8'd100, '{24'hC00000, 8'd101, 1'b0, 1'b0, 1'b0, sticky_on, 1}};
        tbl[4]  = '{25'h1800001, 8'd254, '{24'h000000, 8'd255, 1'b0, 1'b0, 1'b1, sticky_on, 1}};
        tbl[5]  = '{25'h0000000, 8'd77,  '{24'h000000, 8'd0,   1'b1, 1'b0, 1'b0, 1'b0, 1}};
        tbl[6]  = '{25'h0123456, 8'd255, '{24'h123456, 8'd255, 1'b0, 1'b0, 1'b0, 1'b0, 1}};
        tbl[7]  = '{25'h0000ABC, 8'd0,   '{24'h000ABC, 8'd0,   1'b0, 1'b1, 1'b0, 1'b0, 1}};
        tbl[8]  = '{25'h0400000, 8'd1,   '{24'h400000, 8'd0,   1'b0, 1'b1, 1'b0, 1'b0, 2}};
        tbl[9]  = '{25'h0000001, 8'd1,   '{24'h000001, 8'd0,   1'b0, 1'b1, 1'b0, 1'b0, 2}};
        tbl[10] = '{25'h0000001, 8'd24,  '{24'h800000, 8'd1,   1'b0, 1'b0, 1'b0, 1'b0, 25}};
        tbl[11] = '{25'h1FFFFFF, 8'd0,   '{24'hFFFFFF, 8'd1,   1'b0, 1'b0, 1'b0, sticky_on, 1}};

        bus.in_valid    = 1'b0;
        bus.in_mantissa = '0;
        bus.in_exponent = '0;
        bus.out_ready   = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.handshake", {30'h0, bus.in_ready, bus.out_valid}, 32'b10);
        chk("reset.data", {bus.out_mantissa, bus.out_exponent}, 32'h0);
        chk("reset.flags", {28'h0, bus.zero, bus.underflow, bus.overflow, bus.sticky}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("tbl%0d", i), tbl[i].m, tbl[i].e, tbl[i].want);
        end

        // Zero result held under backpressure while a competing operand is offered.
        @(negedge clk);
        bus.in_mantissa = 25'h0;
        bus.in_exponent = 8'd77;
        bus.in_valid    = 1'b1;
        @(posedge clk);
        #1;
        bus.in_mantissa = 25'h0800000;
        bus.in_exponent = 8'd10;
        held_mant = bus.out_mantissa;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp%0d.hold", c), {29'h0, bus.out_valid, bus.in_ready, bus.zero}, 32'b101);
            chk($sformatf("bp%0d.data", c), {bus.out_mantissa, bus.out_exponent}, {held_mant, 8'd0});
        end
        $display("op backpressure zero held 5 cycles z=%0b exp=%0d", bus.zero, bus.out_exponent);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("bp.release", {29'h0, bus.out_valid, bus.in_ready, bus.zero}, 32'b010);

        // Asynchronous reset in the middle of a long normalization.
        @(negedge clk);
        bus.in_mantissa = 25'h0000001;
        bus.in_exponent = 8'd100;
        bus.in_valid    = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst.busy", {30'h0, bus.in_ready, bus.out_valid}, 32'b00);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst.async", {30'h0, bus.in_ready, bus.out_valid}, 32'b10);
        chk("rst.data", {bus.out_mantissa, bus.out_exponent}, 32'h0);
        $display("op reset mid-shift in_ready=%0b out_valid=%0b", bus.in_ready, bus.out_valid);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst", tbl[2].m, tbl[2].e, tbl[2].want);

        for (int i = 0; i < 40; i++) begin
            rm = 25'($urandom) >> $urandom_range(0, 25);
            case ($urandom_range(0, 5))
                0: re = 8'd0;
                1: re = 8'd1;
                2: re = 8'd255;
                3: re = 8'd254;
                4: re = 8'($urandom_range(1, 30));
                default: re = 8'($urandom_range(0, 255));
            endcase
            w = model(rm, re);
            run_op($sformatf("rnd%0d", i), rm, re, w);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/iterative_normalizer.md
# iterative_normalizer

Post-operation normalizer for the add/sub datapath. It takes the raw sum/difference mantissa (including carry-out bit) and the pre-normalization exponent, and returns an IEEE-style normalized mantissa and adjusted exponent. This is the inverse of the alignment stage: alignment right-shifts by the exponent difference, and this block left-shifts out leading zeros, decrementing the exponent as it goes. Processing is iterative, one bit per cycle, with valid/ready handshakes on both sides.

## Interface
- ExponentSize, 8, exponent field width
- MantissaSize, 24, significand width including hidden bit
- Clock  input  1  rising-edge clock
- ResetN  input  1  asynchronous, active-low reset
- InValid  input  1  input operands valid
- InReady  output  1  block can accept; high only in IDLE
- InMantissa  input  MantissaSize+1  raw mantissa; bit MantissaSize is the carry-out
- InExponent  input  ExponentSize  pre-normalization exponent
- OutValid  output  1  result valid; high only in DONE
- OutReady  input  1  downstream accepts result
- OutMantissa  output  MantissaSize  normalized significand (MSB is the hidden bit)
- OutExponent  output  ExponentSize  adjusted exponent
- Zero  output  1  result mantissa is zero
- Underflow  output  1  result is denormal (exponent limit hit before normalization)
- Overflow  output  1  exponent saturated to all-ones; mantissa forced to 0
- Sticky  output  1  OR of bits shifted out on the right (see Configuration)

## Operation
- FSM states are IDLE, SHIFT and DONE. InReady = (state==IDLE). OutValid = (state==DONE).
- Accept occurs when InValid && InReady at a rising edge. The operands are registered and classified as follows:
  - InExponent all-ones (Inf/NaN): pass the mantissa low MantissaSize bits through unchanged. Go to DONE.
  - InMantissa == 0: OutMantissa = 0, OutExponent = 0, Zero = 1. Go to DONE.
  - Carry bit set: right-shift by 1 and increment the exponent. If the result is all-ones, set Overflow = 1 and OutMantissa = 0. Go to DONE.
  - InExponent == 0 with nonzero mantissa (already denormal): no shift, Underflow = 1. Go to DONE.
  - Otherwise: go to SHIFT.
- SHIFT evaluates once per cycle, in this order:
  - Mantissa MSB (bit MantissaSize-1) = 1: go to DONE.
  - Else if exponent == 1: set the exponent to 0, set Underflow = 1, leave the mantissa unshifted, go to DONE.
  - Else: shift the mantissa left by 1 (zero fill), decrement the exponent, stay in SHIFT.
- DONE holds all outputs stable until OutReady = 1. On that handshake, go to IDLE and clear the flags.
- An accept cannot occur in the same cycle as an output handshake. The next accept is at the earliest edge after the return to IDLE.
- All arithmetic is unsigned and ExponentSize wide. The exponent never wraps: the exponent == 1 and all-ones checks prevent it.

## Timing
- Reset values: state IDLE, InReady = 1, OutValid = 0, and OutMantissa, OutExponent, Zero, Underflow, Overflow, Sticky all 0.
- Special, zero and carry cases: OutValid rises at the first edge after accept (latency 1).
- Normal case with k leading zeros: latency is 2 + k cycles when not exponent-limited. The worst case is MantissaSize+1.
- Exponent-limited case: latency is 2 + (InExponent - 1).
- ResetN asserted mid-SHIFT or in DONE returns immediately (asynchronously) to the reset values. The in-flight operand is discarded.
- The inputs are sampled only at accept. Changes while the block is busy are ignored.

## Configuration
- NORMALIZER_STICKY_EN
  - Defined: in the carry right-shift case, Sticky = InMantissa[0] (the bit shifted out). Sticky is 0 in all other cases and is held through DONE.
  - Undefined: Sticky is tied to 0, and no sticky register is built.

## Test plan
- Normalized input, InMantissa=25'h0800000, InExponent=100 → OutMantissa=24'h800000, OutExponent=100, OutValid 2 cycles after accept, all flags 0.
- Deep normalization, InMantissa=25'h0000001, InExponent=100 → OutMantissa=24'h800000, OutExponent=77, OutValid 25 cycles after accept.
- Underflow, InMantissa=25'h0000100, InExponent=5 → 4 shifts, OutMantissa=24'h001000, OutExponent=0, Underflow=1, latency 6.
- Carry and overflow:
  - InMantissa=25'h1800001, InExponent=100 → OutMantissa=24'hC00000, OutExponent=101, Sticky=1 (macro defined) or 0 (undefined).
  - Same mantissa with InExponent=254 → OutExponent=255, OutMantissa=0, Overflow=1.
- Zero and backpressure: InMantissa=0, InExponent=77 → Zero=1, OutExponent=0. Hold OutReady=0 for 5 cycles; outputs stay stable, InReady stays 0, and new InValid is ignored.
- Reset mid-operation: assert ResetN=0 during SHIFT of the deep-normalization case → InReady=1 and OutValid=0 immediately. The next operand after release produces the correct result.
